// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared constants and the instruction-memory loader state encoding
//           used by the loader and by processor-level benches.
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } loader_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Purpose : Big-endian byte-to-word shift register. Each shifted byte enters
//           at bits [7:0] and the older bytes move up, so the first byte of
//           a word ends in bits [31:24] after four shifts.
// Rev     : 1.0  initial release
// ============================================================================
module byte_packer
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clear,
   input  logic                  i_shift_in,
   input  logic [7:0]            i_byte,
   output logic [WORD_WIDTH-1:0] o_word,
   output logic                  o_word_full
);

   logic [WORD_WIDTH-1:0] r_word;
   logic [1:0]            r_byte_idx;

   // Shift register and byte index; clear wins over a concurrent shift.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_word     <= '0;
         r_byte_idx <= 2'd0;
      end else if (i_shift_in) begin
         r_word     <= {r_word[WORD_WIDTH-9:0], i_byte};
         r_byte_idx <= r_byte_idx + 2'd1;
      end
   end

   assign o_word      = r_word;
   // High when the next shifted byte is the 4th of the current word.
   assign o_word_full = (r_byte_idx == 2'd3);

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Boot-time instruction memory loader. Parses a 16-bit word-count
//           header, packs big-endian words from a byte stream and writes them
//           to instruction memory while holding the CPU in reset.
// Rev     : 1.0  initial release
// ============================================================================
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [WORD_WIDTH-1:0] wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [31:0] c_CAPACITY = 32'(2 ** ADDR_WIDTH);

   loader_state_t         r_state;
   logic                  r_in_ready;
   logic                  r_wr_en;
   logic                  r_last_wr;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic                  r_cpu_hold;
   logic                  r_done;
   logic                  r_error;
   logic [15:0]           r_count;
   logic [ADDR_WIDTH:0]   r_word_idx;

   logic                  w_xfer;
   logic [15:0]           w_hdr_n;
   logic [WORD_WIDTH-1:0] w_word;
   logic                  w_word_full;
   logic                  w_last_word;

   assign w_xfer      = in_valid && r_in_ready;
   assign w_hdr_n     = {r_count[15:8], in_byte};
   // Word index is one bit wider than the address so N = capacity is reachable.
   assign w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_count));

   byte_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (r_state != DATA),
      .i_shift_in  (w_xfer && (r_state == DATA)),
      .i_byte      (in_byte),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   // Loader FSM with registered handshake, write strobe and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_last_wr  <= 1'b0;
         r_wr_addr  <= '0;
         r_cpu_hold <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_count    <= '0;
         r_word_idx <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  r_state    <= HDR_HI;
                  r_in_ready <= 1'b1;
                  r_cpu_hold <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
               end
            end
            HDR_HI: begin
               if (w_xfer) begin
                  r_count[15:8] <= in_byte;
                  r_state       <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (w_xfer) begin
                  r_count[7:0] <= in_byte;
                  r_word_idx   <= '0;
                  r_last_wr    <= 1'b0;
                  if (w_hdr_n == 16'd0) begin
                     r_state    <= DONE;
                     r_in_ready <= 1'b0;
                     r_cpu_hold <= 1'b0;
                     r_done     <= 1'b1;
                  end else if (32'(w_hdr_n) > c_CAPACITY) begin
                     r_state    <= ERROR;
                     r_in_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (r_wr_en && r_last_wr) begin
                  r_state    <= DONE;
                  r_cpu_hold <= 1'b0;
                  r_done     <= 1'b1;
               end else if (w_xfer && w_word_full) begin
                  r_wr_en    <= 1'b1;
                  r_wr_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                  r_word_idx <= r_word_idx + 1'b1;
                  r_last_wr  <= w_last_word;
                  // Nothing follows the final word, so stop accepting bytes.
                  if (w_last_word) begin
                     r_in_ready <= 1'b0;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = w_word;
   assign cpu_hold = r_cpu_hold;
   assign done     = r_done;
   assign error    = r_error;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Directed self-checking bench for the instruction memory loader.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0]  q_addr[$];
   logic [31:0] q_data[$];

   imem_loader #(.ADDR_WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Log every write, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   // Present a byte and hold it until the edge that accepts it.
   task automatic send(input logic [7:0] b);
      int k;
      in_valid = 1'b1;
      in_byte  = b;
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) check("send_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_byte  = 8'hFF;
      @(negedge clk);
   endtask

   task automatic wait_done();
      int k;
      in_valid = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("wait_done", 64'(done), 64'd1);
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] exp3[3];
      int          bad;

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_wr_en",    64'(wr_en),    64'd0);
      check("rst_wr_addr",  64'(wr_addr),  64'd0);
      check("rst_wr_data",  64'(wr_data),  64'd0);
      check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      check("rst_done",     64'(done),     64'd0);
      check("rst_error",    64'(error),    64'd0);

      // Single word at full rate
      clear_log();
      pulse_start();
      check("t1_in_ready_hdr", 64'(in_ready), 64'd1);
      send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      in_valid = 1'b0;
      check("t1_wr_en",   64'(wr_en),   64'd1);
      check("t1_wr_addr", 64'(wr_addr), 64'd0);
      check("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
      @(negedge clk);
      check("t1_wr_en_low", 64'(wr_en),    64'd0);
      check("t1_done",      64'(done),     64'd1);
      check("t1_cpu_hold",  64'(cpu_hold), 64'd0);
      check("t1_in_ready",  64'(in_ready), 64'd0);
      check("t1_nwrites",   64'(q_addr.size()), 64'd1);

      // Three words with a stall before every data byte
      clear_log();
      exp3[0] = 32'h20080005; exp3[1] = 32'h01094020; exp3[2] = 32'hAC080000;
      pulse_start();
      check("t2_done_cleared", 64'(done),     64'd0);
      check("t2_cpu_hold",     64'(cpu_hold), 64'd1);
      send(8'h00); send(8'h03);
      for (int i = 0; i < 3; i++) begin
         w = exp3[i];
         for (int j = 3; j >= 0; j--) begin
            idle_cycle();
            send(w[j*8 +: 8]);
         end
      end
      wait_done();
      check("t2_nwrites", 64'(q_addr.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < q_addr.size()) begin
            check("t2_addr", 64'(q_addr[i]), 64'(i));
            check("t2_data", 64'(q_data[i]), 64'(exp3[i]));
         end
      end

      // Zero-length load
      clear_log();
      pulse_start();
      send(8'h00); send(8'h00);
      in_valid = 1'b0;
      check("t3_done",     64'(done),     64'd1);
      check("t3_cpu_hold", 64'(cpu_hold), 64'd0);
      check("t3_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(negedge clk);
      check("t3_nwrites", 64'(q_addr.size()), 64'd0);

      // Oversized header
      clear_log();
      pulse_start();
      send(8'h01); send(8'h01);
      check("t4_error",    64'(error),    64'd1);
      check("t4_cpu_hold", 64'(cpu_hold), 64'd1);
      check("t4_done",     64'(done),     64'd0);
      in_byte = 8'h55;
      repeat (3) @(negedge clk);
      check("t4_in_ready", 64'(in_ready), 64'd0);
      check("t4_error_held", 64'(error),  64'd1);
      check("t4_nwrites", 64'(q_addr.size()), 64'd0);
      in_valid = 1'b0;

      // Full-capacity load: 256 words
      pulse_start();
      check("t4b_error_cleared", 64'(error), 64'd0);
      send(8'h01); send(8'h00);
      for (int i = 0; i < 256; i++) begin
         send(8'hA5); send(8'(i)); send(8'h5A); send(~8'(i));
      end
      wait_done();
      check("t4b_nwrites", 64'(q_addr.size()), 64'd256);
      bad = 0;
      for (int i = 0; i < q_addr.size(); i++) begin
         if (q_addr[i] !== 8'(i) ||
             q_data[i] !== {8'hA5, 8'(i), 8'h5A, ~8'(i)}) bad++;
      end
      check("t4b_bad_words", 64'(bad), 64'd0);
      if (q_addr.size() > 0)
         check("t4b_last_addr", 64'(q_addr[q_addr.size()-1]), 64'hFF);

      // Reset in the middle of a two-word load
      clear_log();
      pulse_start();
      send(8'h00); send(8'h02);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55); send(8'h66);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_in_ready", 64'(in_ready), 64'd0);
      check("t5_wr_en",    64'(wr_en),    64'd0);
      check("t5_wr_addr",  64'(wr_addr),  64'd0);
      check("t5_wr_data",  64'(wr_data),  64'd0);
      check("t5_cpu_hold", 64'(cpu_hold), 64'd1);
      check("t5_done",     64'(done),     64'd0);
      check("t5_error",    64'(error),    64'd0);
      repeat (4) @(negedge clk);
      check("t5_nwrites", 64'(q_addr.size()), 64'd1);
      if (q_addr.size() > 0) check("t5_first_data", 64'(q_data[0]), 64'h11223344);
      clear_log();
      pulse_start();
      send(8'h00); send(8'h01);
      send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
      wait_done();
      check("t5_reload_n", 64'(q_addr.size()), 64'd1);
      if (q_addr.size() > 0) begin
         check("t5_reload_addr", 64'(q_addr[0]), 64'd0);
         check("t5_reload_data", 64'(q_data[0]), 64'hCAFEBABE);
      end

      // Restart from DONE
      clear_log();
      pulse_start();
      check("t6_done_dropped", 64'(done), 64'd0);
      send(8'h00); send(8'h01);
      send(8'h00); send(8'h00); send(8'h00); send(8'h0C);
      in_valid = 1'b0;
      check("t6_wr_en",   64'(wr_en),   64'd1);
      check("t6_wr_addr", 64'(wr_addr), 64'd0);
      check("t6_wr_data", 64'(wr_data), 64'h0000000C);
      check("t6_done_low_in_write", 64'(done), 64'd0);
      @(negedge clk);
      check("t6_done", 64'(done), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_imem_loader
`default_nettype wire
